// File: rtl/pacman_bcd_pkg.sv
// Shared definitions for the score/high-score/level BCD conversion path.
// Provides the BCD digit type, the blank code used by the renderers for
// suppressed leading zeros, and the scheduler FSM state encoding.
// Ports: none (package).
// Configuration macro consumers: SCORE_BCD_BLANK_EN (see score_bcd_scheduler).
package pacman_bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  // Code the seven-segment renderers treat as "segment off".
  localparam bcd_digit_t BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcd_state_t;

  // Double-dabble correction: a digit of 5 or more would overflow past 9
  // after the coming shift, so bias it by 3 first. 4-bit wrap is intended.
  function automatic bcd_digit_t bcd_adjust(input bcd_digit_t d);
    return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bcd_seq_core.sv
// Sequential shift-add-3 (double-dabble) binary-to-BCD engine.
// Ports:
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   start     : load value, clear scratch digits, begin WIDTH iterations
//   value     : binary input sampled when start is high
//   done      : high during the final iteration cycle
//   result    : digits as they will be after the final iteration; only
//               meaningful while done is high (registered by the caller)
module bcd_seq_core
  import pacman_bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH-1:0]        value,
  output logic                    done,
  output logic [DIGITS-1:0][3:0]  result
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  bcd_digit_t [DIGITS-1:0] dig_q;
  bcd_digit_t [DIGITS-1:0] dig_adj;
  bcd_digit_t [DIGITS-1:0] dig_n;
  logic       [WIDTH-1:0]  val_q;
  logic       [WIDTH-1:0]  val_n;
  logic       [CNT_W-1:0]  cnt_q;
  logic                    active_q;

  // One iteration: correct every digit, then shift {digits, value} left by
  // one so the value's MSB enters digit 0's LSB.
  always_comb begin
    dig_adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      dig_adj[d] = bcd_adjust(dig_q[d]);
    end
    {dig_n, val_n} = {dig_adj, val_q} << 1;
  end

  assign done   = active_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign result = dig_n;

  // Iteration counter and scratch registers. A reset simply drops the
  // in-flight conversion; the caller never sees a done for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_q    <= '0;
      val_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      dig_q    <= '0;
      val_q    <= value;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      dig_q <= dig_n;
      val_q <= val_n;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/score_bcd_scheduler.sv
// Round-robin scheduler sharing one sequential BCD engine between several
// score sources; delivers tagged per-digit BCD results to the HUD.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   req_valid  : per-requester "value ready"
//   req_value  : per-requester binary value
//   req_ack    : one-cycle pulse when requester i's value is captured
//   busy       : engine occupied (SHIFT or DONE)
//   out_valid  : one-cycle pulse, result on out_id/out_bcd
//   out_id     : requester index of the result
//   out_bcd    : digit 0 least significant, held until next out_valid
// Configuration: define SCORE_BCD_BLANK_EN to output leading zero digits
// (above the most significant nonzero digit, never digit 0) as BCD_BLANK.
module score_bcd_scheduler
  import pacman_bcd_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_REQ-1:0]                   req_valid,
  input  logic [N_REQ-1:0][WIDTH-1:0]        req_value,
  output logic [N_REQ-1:0]                   req_ack,
  output logic                               busy,
  output logic                               out_valid,
  output logic [(N_REQ>1?$clog2(N_REQ):1)-1:0] out_id,
  output logic [DIGITS-1:0][3:0]             out_bcd
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // ceil(WIDTH * log10(2)) in integer arithmetic.
  localparam int MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000;

  if (DIGITS < MIN_DIGITS) begin : g_digits_check
    $error("score_bcd_scheduler: DIGITS too small for WIDTH");
  end

  bcd_state_t               state_q;
  logic [ID_W-1:0]          last_grant_q;
  logic [ID_W-1:0]          cap_id_q;
  logic                     grant_found;
  logic [ID_W-1:0]          grant_idx;
  logic                     fire;
  logic                     core_done;
  logic [DIGITS-1:0][3:0]   core_result;
  logic [DIGITS-1:0][3:0]   shown;

  // Round-robin search starting just after the last served requester, so a
  // requester that keeps req_valid high waits behind every other asserter.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % N_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  // The ack and the engine start are the same event; reset suppresses both
  // so nothing is captured while the block is being cleared.
  assign fire = !rst && (state_q == ST_IDLE) && grant_found;

  always_comb begin
    req_ack = '0;
    if (fire) begin
      req_ack[grant_idx] = 1'b1;
    end
  end

  assign busy = (state_q != ST_IDLE);

  bcd_seq_core #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (fire),
    .value  (req_value[grant_idx]),
    .done   (core_done),
    .result (core_result)
  );

  // Leading-zero handling applied to the engine result before it is
  // registered onto out_bcd.
  always_comb begin
    shown = core_result;
`ifdef SCORE_BCD_BLANK_EN
    begin
      logic seen;
      seen = 1'b0;
      for (int d = DIGITS - 1; d >= 1; d--) begin
        if (core_result[d] != 4'h0) begin
          seen = 1'b1;
        end
        if (!seen) begin
          shown[d] = BCD_BLANK;
        end
      end
    end
`endif
  end

  // Scheduler FSM. The result is registered on the edge that finishes the
  // last iteration, so out_valid/out_bcd are visible during the DONE cycle
  // and the next grant can happen the cycle after.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ID_W'(N_REQ - 1);
      cap_id_q     <= '0;
      out_valid    <= 1'b0;
      out_id       <= '0;
      out_bcd      <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fire) begin
            cap_id_q <= grant_idx;
            state_q  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (core_done) begin
            out_bcd   <= shown;
            out_id    <= cap_id_q;
            out_valid <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          last_grant_q <= cap_id_q;
          state_q      <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_bcd_scheduler.sv
// Self-checking bench for score_bcd_scheduler (default parameters).
// Honors SCORE_BCD_BLANK_EN in its reference model.
module tb_score_bcd_scheduler;

  localparam int N_REQ  = 2;
  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;

  logic                         clk;
  logic                         rst;
  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0][WIDTH-1:0]  req_value;
  logic [N_REQ-1:0]             req_ack;
  logic                         busy;
  logic                         out_valid;
  logic [0:0]                   out_id;
  logic [DIGITS-1:0][3:0]       out_bcd;

  int vectors;
  int miscompares;
  int last_grant;
  logic [DIGITS-1:0][3:0] prev_exp;

  score_bcd_scheduler #(
    .N_REQ  (N_REQ),
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_value (req_value),
    .req_ack   (req_ack),
    .busy      (busy),
    .out_valid (out_valid),
    .out_id    (out_id),
    .out_bcd   (out_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Decimal digits of v by plain division, blanked above the top nonzero
  // digit when the blanking build is selected.
  function automatic logic [DIGITS-1:0][3:0] ref_bcd(input int unsigned v);
    logic [DIGITS-1:0][3:0] r;
    int unsigned p;
    int msd;
    p = 1;
    msd = 0;
    for (int d = 0; d < DIGITS; d++) begin
      r[d] = 4'((v / p) % 10);
      if (r[d] != 4'h0) msd = d;
      p = p * 10;
    end
`ifdef SCORE_BCD_BLANK_EN
    for (int d = 1; d < DIGITS; d++) begin
      if (d > msd) r[d] = 4'hF;
    end
`endif
    return r;
  endfunction

  function automatic int rr_pick(input logic [N_REQ-1:0] m, input int last);
    for (int k = 1; k <= N_REQ; k++) begin
      if (m[(last + k) % N_REQ]) return (last + k) % N_REQ;
    end
    return -1;
  endfunction

  // One full request: grant, WIDTH busy cycles, tagged result on the next.
  task automatic convert_one(input logic [N_REQ-1:0] mask,
                             input logic [WIDTH-1:0] v0,
                             input logic [WIDTH-1:0] v1,
                             input bit scramble,
                             input bit drop);
    int g;
    logic [WIDTH-1:0] cap;
    logic [DIGITS-1:0][3:0] exp;
    logic [N_REQ-1:0] exp_ack;
    @(negedge clk);
    req_valid    = mask;
    req_value[0] = v0;
    req_value[1] = v1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_bcd !== prev_exp) begin
      $display("[TB] FAIL held: out_valid=%b out_bcd=%h, want 0 / %h", out_valid, out_bcd, prev_exp);
      miscompares++;
    end
    g = rr_pick(mask, last_grant);
    exp_ack = '0;
    exp_ack[g] = 1'b1;
    vectors++;
    if (req_ack !== exp_ack) begin
      $display("[TB] FAIL ack: req_ack=%b, want %b", req_ack, exp_ack);
      miscompares++;
      req_valid = '0;
      repeat (WIDTH + 4) @(negedge clk);
      return;
    end
    cap = (g == 0) ? v0 : v1;
    exp = ref_bcd(int'(cap));
    for (int k = 1; k <= WIDTH + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (scramble) begin
          req_value[0] = WIDTH'($urandom);
          req_value[1] = WIDTH'($urandom);
        end
        if (drop) req_valid = '0;
      end
      #1;
      vectors++;
      if (req_ack !== '0) begin
        $display("[TB] FAIL ack_while_busy: cycle %0d req_ack=%b, want 00", k, req_ack);
        miscompares++;
      end
      vectors++;
      if (k <= WIDTH) begin
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
          $display("[TB] FAIL shift: cycle %0d busy=%b out_valid=%b, want 1/0", k, busy, out_valid);
          miscompares++;
        end
      end else begin
        if (busy !== 1'b1 || out_valid !== 1'b1 || out_id !== 1'(g) || out_bcd !== exp) begin
          $display("[TB] FAIL result: value=%0d busy=%b valid=%b id=%0d bcd=%h, want 1/1/%0d/%h",
                   cap, busy, out_valid, out_id, out_bcd, g, exp);
          miscompares++;
        end
      end
    end
    last_grant = g;
    prev_exp   = exp;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    req_value = '0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_id !== 1'b0 || out_bcd !== '0 || req_ack !== '0) begin
      $display("[TB] FAIL reset: busy=%b valid=%b id=%b bcd=%h ack=%b, want all 0",
               busy, out_valid, out_id, out_bcd, req_ack);
      miscompares++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || req_ack !== '0 || out_valid !== 1'b0) begin
      $display("[TB] FAIL idle: busy=%b ack=%b valid=%b, want 0", busy, req_ack, out_valid);
      miscompares++;
    end
    last_grant = N_REQ - 1;
    prev_exp   = '0;
  endtask

  task automatic test_known_values();
    convert_one(2'b01, 16'd1234, 16'd0, 1'b0, 1'b1);
    convert_one(2'b01, 16'hFFFF, 16'd0, 1'b0, 1'b1);
    convert_one(2'b01, 16'd0,    16'd0, 1'b0, 1'b1);
    convert_one(2'b10, 16'd0,    16'd907, 1'b0, 1'b1);
    convert_one(2'b10, 16'd0,    16'd10000, 1'b0, 1'b1);
  endtask

  task automatic test_capture();
    convert_one(2'b01, 16'd4321, 16'd0, 1'b1, 1'b1);
    convert_one(2'b10, 16'd0, 16'd65000, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      convert_one(2'b11, 16'd100, 16'd200, 1'b0, 1'b0);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_shift();
    @(negedge clk);
    req_valid    = 2'b01;
    req_value[0] = 16'd12345;
    #1;
    vectors++;
    if (req_ack !== 2'b01) begin
      $display("[TB] FAIL mid_ack: req_ack=%b, want 01", req_ack);
      miscompares++;
    end
    repeat (6) @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_id !== 1'b0 || out_bcd !== '0) begin
      $display("[TB] FAIL mid_reset: busy=%b valid=%b id=%b bcd=%h, want all 0",
               busy, out_valid, out_id, out_bcd);
      miscompares++;
    end
    rst = 1'b0;
    for (int k = 0; k < WIDTH + 8; k++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        $display("[TB] FAIL aborted: cycle %0d out_valid=%b busy=%b, want 0/0", k, out_valid, busy);
        miscompares++;
      end
    end
    last_grant = N_REQ - 1;
    prev_exp   = '0;
    convert_one(2'b11, 16'd1234, 16'd5678, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [N_REQ-1:0] m;
    for (int i = 0; i < 2000; i++) begin
      m = N_REQ'($urandom_range(1, 3));
      convert_one(m, WIDTH'($urandom), WIDTH'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    req_valid = '0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_known_values();
    test_capture();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
